// File: rtl/mem_arbiter.sv
// Arbiter that shares one single-port, variable-latency memory between the fetch
// (instruction) port and the memory-stage (data) port, with data-over-instruction priority.
module mem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          ireq,
    input  logic [AW-1:0] iaddr,
    output logic [DW-1:0] irdata,
    output logic          istall,

    input  logic          dreq,
    input  logic          dwe,
    input  logic [AW-1:0] daddr,
    input  logic [DW-1:0] dwdata,
    output logic [DW-1:0] drdata,
    output logic          dstall,

    output logic          mreq,
    output logic          mwe,
    output logic [AW-1:0] maddr,
    output logic [DW-1:0] mwdata,
    input  logic [DW-1:0] mrdata,
    input  logic          mready
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_IBUSY = 2'd1;
    localparam logic [1:0] S_DBUSY = 2'd2;

    logic [1:0]    state_q,  state_d;
    logic          mreq_q,   mreq_d;
    logic          mwe_q,    mwe_d;
    logic [AW-1:0] maddr_q,  maddr_d;
    logic [DW-1:0] mwdata_q, mwdata_d;
    logic [DW-1:0] irdata_q, irdata_d;
    logic [DW-1:0] drdata_q, drdata_d;
    logic          ivalid_q, ivalid_d;
    logic          dvalid_q, dvalid_d;

    logic ipend;
    logic dpend;
    logic adv;

    // A valid flag masks its port's request until the pipeline advances and consumes it.
    assign ipend = ireq & ~ivalid_q;
    assign dpend = dreq & ~dvalid_q;
    assign adv   = ~ipend & ~dpend;

    assign istall = ipend;
    assign dstall = dpend;

    assign mreq   = mreq_q;
    assign mwe    = mwe_q;
    assign maddr  = maddr_q;
    assign mwdata = mwdata_q;
    assign irdata = irdata_q;
    assign drdata = drdata_q;

    always_comb begin
        // NOTE: every signal gets a default hold value first so no path leaves it unassigned and no latch is inferred.
        state_d  = state_q;
        mreq_d   = mreq_q;
        mwe_d    = mwe_q;
        maddr_d  = maddr_q;
        mwdata_d = mwdata_q;
        irdata_d = irdata_q;
        drdata_d = drdata_q;
        ivalid_d = ivalid_q;
        dvalid_d = dvalid_q;

        case (state_q)
            S_IDLE: begin
                if (dpend) begin
                    state_d  = S_DBUSY;
                    mreq_d   = 1'b1;
                    mwe_d    = dwe;
                    maddr_d  = daddr;
                    mwdata_d = dwdata;
                end else if (ipend) begin
                    state_d  = S_IBUSY;
                    mreq_d   = 1'b1;
                    mwe_d    = 1'b0;
                    maddr_d  = iaddr;
                end else begin
                    mreq_d   = 1'b0;
                end
            end
            S_IBUSY: begin
                if (mready) begin
                    state_d  = S_IDLE;
                    mreq_d   = 1'b0;
                    ivalid_d = 1'b1;
                    irdata_d = mrdata;
                end
            end
            S_DBUSY: begin
                if (mready) begin
                    state_d  = S_IDLE;
                    mreq_d   = 1'b0;
                    dvalid_d = 1'b1;
                    if (!mwe_q) begin
                        drdata_d = mrdata;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                mreq_d  = 1'b0;
            end
        endcase

        // Completion and advance coincide only if the requester withdrew; the result is then dropped.
        if (adv) begin
            ivalid_d = 1'b0;
            dvalid_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            mreq_q   <= 1'b0;
            mwe_q    <= 1'b0;
            maddr_q  <= '0;
            mwdata_q <= '0;
            irdata_q <= '0;
            drdata_q <= '0;
            ivalid_q <= 1'b0;
            dvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            mreq_q   <= mreq_d;
            mwe_q    <= mwe_d;
            maddr_q  <= maddr_d;
            mwdata_q <= mwdata_d;
            irdata_q <= irdata_d;
            drdata_q <= drdata_d;
            ivalid_q <= ivalid_d;
            dvalid_q <= dvalid_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small memory model whose wait-state count is
// set per test; expected values are worked out by hand from the arbiter's timing rules.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk;
    logic          reset;
    logic          ireq;
    logic [AW-1:0] iaddr;
    logic [DW-1:0] irdata;
    logic          istall;
    logic          dreq;
    logic          dwe;
    logic [AW-1:0] daddr;
    logic [DW-1:0] dwdata;
    logic [DW-1:0] drdata;
    logic          dstall;
    logic          mreq;
    logic          mwe;
    logic [AW-1:0] maddr;
    logic [DW-1:0] mwdata;
    logic [DW-1:0] mrdata;
    logic          mready;

    int n_checks = 0;
    int n_fail   = 0;

    // Memory model: completes after wait_states extra mreq cycles; force_rdy pulses mready regardless.
    int   wait_states;
    int   wait_cnt;
    logic force_rdy;

    assign mready = force_rdy | (mreq && (wait_cnt == wait_states));
    assign mrdata = (maddr == 32'h40) ? 32'hDEAD_BEEF : (32'hA5A5_0000 | maddr);

    always @(posedge clk) begin
        if (!mreq || mready) wait_cnt <= 0;
        else                 wait_cnt <= wait_cnt + 1;
    end

    mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk    (clk),
        .reset  (reset),
        .ireq   (ireq),
        .iaddr  (iaddr),
        .irdata (irdata),
        .istall (istall),
        .dreq   (dreq),
        .dwe    (dwe),
        .daddr  (daddr),
        .dwdata (dwdata),
        .drdata (drdata),
        .dstall (dstall),
        .mreq   (mreq),
        .mwe    (mwe),
        .maddr  (maddr),
        .mwdata (mwdata),
        .mrdata (mrdata),
        .mready (mready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs are driven just after the rising edge; outputs are checked on the falling edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        reset       = 1'b1;
        ireq        = 1'b0;
        iaddr       = '0;
        dreq        = 1'b0;
        dwe         = 1'b0;
        daddr       = '0;
        dwdata      = '0;
        wait_states = 0;
        force_rdy   = 1'b0;

        // Reset state
        cyc();
        cyc();
        reset = 1'b0;
        mid();
        check("rst_mreq",   mreq,   0);
        check("rst_mwe",    mwe,    0);
        check("rst_maddr",  maddr,  0);
        check("rst_mwdata", mwdata, 0);
        check("rst_irdata", irdata, 0);
        check("rst_drdata", drdata, 0);
        check("rst_istall", istall, 0);
        check("rst_dstall", dstall, 0);

        // Zero-wait load
        cyc(); dreq = 1'b1; dwe = 1'b0; daddr = 32'h40;
        mid();
        check("ld_c0_dstall", dstall, 1);
        check("ld_c0_mreq",   mreq,   0);
        cyc(); mid();
        check("ld_c1_mreq",   mreq,   1);
        check("ld_c1_maddr",  maddr,  32'h40);
        check("ld_c1_mwe",    mwe,    0);
        check("ld_c1_dstall", dstall, 1);
        cyc(); mid();
        check("ld_c2_mreq",   mreq,   0);
        check("ld_c2_dstall", dstall, 0);
        check("ld_c2_drdata", drdata, 32'hDEAD_BEEF);
        cyc(); dreq = 1'b0;
        mid();
        check("ld_c3_mreq",   mreq,   0);
        check("ld_c3_drdata", drdata, 32'hDEAD_BEEF);

        // Simultaneous requests, zero-wait: data first, then fetch
        cyc(); ireq = 1'b1; iaddr = 32'h100; dreq = 1'b1; daddr = 32'h200;
        mid();
        check("sim_c0_istall", istall, 1);
        check("sim_c0_dstall", dstall, 1);
        cyc(); mid();
        check("sim_c1_mreq",  mreq,  1);
        check("sim_c1_maddr", maddr, 32'h200);
        cyc(); mid();
        check("sim_c2_dstall", dstall, 0);
        check("sim_c2_istall", istall, 1);
        check("sim_c2_mreq",   mreq,   0);
        check("sim_c2_drdata", drdata, 32'hA5A5_0200);
        cyc(); mid();
        check("sim_c3_mreq",   mreq,   1);
        check("sim_c3_maddr",  maddr,  32'h100);
        check("sim_c3_mwe",    mwe,    0);
        check("sim_c3_dstall", dstall, 0);
        cyc(); mid();
        check("sim_c4_istall", istall, 0);
        check("sim_c4_dstall", dstall, 0);
        check("sim_c4_irdata", irdata, 32'hA5A5_0100);
        check("sim_c4_drdata", drdata, 32'hA5A5_0200);
        cyc(); ireq = 1'b0; dreq = 1'b0;
        mid();
        check("sim_c5_mreq", mreq, 0);

        // Store with three wait states; requester inputs change mid-transaction
        wait_states = 3;
        cyc(); dreq = 1'b1; dwe = 1'b1; daddr = 32'h8; dwdata = 32'h1234;
        mid();
        check("st_c0_dstall", dstall, 1);
        for (int k = 0; k < 4; k++) begin
            cyc();
            if (k == 1) begin
                daddr  = 32'hFFFF;
                dwdata = 32'hBAD0;
            end
            mid();
            check("st_busy_mreq",   mreq,   1);
            check("st_busy_mwe",    mwe,    1);
            check("st_busy_maddr",  maddr,  32'h8);
            check("st_busy_mwdata", mwdata, 32'h1234);
            check("st_busy_dstall", dstall, 1);
        end
        cyc(); mid();
        check("st_done_dstall", dstall, 0);
        check("st_done_mreq",   mreq,   0);
        check("st_done_drdata", drdata, 32'hA5A5_0200);
        cyc(); dreq = 1'b0; dwe = 1'b0;
        mid();
        check("st_after_mreq", mreq, 0);

        // Fetch completes while the data port is still stalled
        wait_states = 2;
        cyc(); ireq = 1'b1; iaddr = 32'h300;
        mid();
        check("fd_c0_istall", istall, 1);
        cyc(); dreq = 1'b1; dwe = 1'b0; daddr = 32'h400;
        mid();
        check("fd_c1_mreq",   mreq,   1);
        check("fd_c1_maddr",  maddr,  32'h300);
        check("fd_c1_dstall", dstall, 1);
        cyc(); mid();
        check("fd_c2_mreq", mreq, 1);
        cyc(); mid();
        check("fd_c3_mreq", mreq, 1);
        cyc(); mid();
        check("fd_c4_istall", istall, 0);
        check("fd_c4_dstall", dstall, 1);
        check("fd_c4_mreq",   mreq,   0);
        check("fd_c4_irdata", irdata, 32'hA5A5_0300);
        for (int k = 0; k < 3; k++) begin
            cyc(); mid();
            check("fd_dbusy_mreq",   mreq,   1);
            check("fd_dbusy_maddr",  maddr,  32'h400);
            check("fd_dbusy_istall", istall, 0);
            check("fd_dbusy_irdata", irdata, 32'hA5A5_0300);
        end
        cyc(); mid();
        check("fd_c8_istall", istall, 0);
        check("fd_c8_dstall", dstall, 0);
        check("fd_c8_drdata", drdata, 32'hA5A5_0400);
        check("fd_c8_irdata", irdata, 32'hA5A5_0300);
        wait_states = 0;
        cyc(); iaddr = 32'h304; dreq = 1'b0;
        mid();
        check("fd_c9_istall", istall, 1);
        check("fd_c9_mreq",   mreq,   0);
        cyc(); mid();
        check("fd_c10_mreq",  mreq,  1);
        check("fd_c10_maddr", maddr, 32'h304);
        cyc(); mid();
        check("fd_c11_istall", istall, 0);
        check("fd_c11_irdata", irdata, 32'hA5A5_0304);
        cyc(); ireq = 1'b0;
        mid();

        // Reset during a data transaction, then mready pulses while idle
        wait_states = 10;
        cyc(); dreq = 1'b1; dwe = 1'b1; daddr = 32'h500; dwdata = 32'h55;
        mid();
        check("rb_c0_dstall", dstall, 1);
        cyc(); reset = 1'b1;
        mid();
        check("rb_c1_mreq", mreq, 1);
        check("rb_c1_mwe",  mwe,  1);
        cyc(); reset = 1'b0; dreq = 1'b0; dwe = 1'b0;
        mid();
        check("rb_mreq",   mreq,   0);
        check("rb_mwe",    mwe,    0);
        check("rb_maddr",  maddr,  0);
        check("rb_mwdata", mwdata, 0);
        check("rb_irdata", irdata, 0);
        check("rb_drdata", drdata, 0);
        check("rb_istall", istall, 0);
        check("rb_dstall", dstall, 0);
        cyc(); force_rdy = 1'b1;
        mid();
        cyc(); force_rdy = 1'b0;
        mid();
        check("rb_idle_mreq",   mreq,   0);
        check("rb_idle_drdata", drdata, 0);
        check("rb_idle_irdata", irdata, 0);

        // Idle with mready toggling
        for (int i = 0; i < 10; i++) begin
            cyc(); force_rdy = (i % 2 == 1);
            mid();
            check("idle_mreq",   mreq,   0);
            check("idle_istall", istall, 0);
            check("idle_dstall", dstall, 0);
        end
        force_rdy = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
